// File: rtl/adder_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adder_share_arbiter                                          |
// | Description : Time-shares one external combinational adder between N_REQ   |
// |               requesters using round-robin arbitration. Operands and the   |
// |               result are registered; one operation takes at least three    |
// |               cycles (IDLE grant, EXEC add, RESP handshake).               |
// | Ports       : clk/rst            clock, async active-high reset           |
// |               req_valid/ready    per-requester request handshake          |
// |               req_a/req_b        packed operands, slice i*WIDTH +: WIDTH  |
// |               rsp_valid/ready    per-requester response handshake         |
// |               rsp_data           shared registered result bus             |
// |               add_a/add_b/add_c  connection to the shared adder           |
// |               busy, grant_id     status                                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module adder_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    input  logic [WIDTH-1:0]       add_c,
    output logic                   busy,
    output logic [IDW-1:0]         grant_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_grant_id;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_rsp_data;

    logic             w_found;
    logic [IDW-1:0]   w_grant;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_rsp_take;
    logic [IDW-1:0]   w_rr_next;

    // Requester index at distance k from base, wrapping at N_REQ (which need
    // not be a power of two, so plain bit truncation is not enough).
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return IDW'(s);
    endfunction

    // Round-robin arbiter: scan from rr_ptr upward, first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_found && (IDW'(i) == wrap_idx(r_rr_ptr, k)) && req_valid[i]) begin
                    w_found = 1'b1;
                    w_grant = IDW'(i);
                end
            end
        end
    end

    // Operand mux, handshake strobes and response acceptance.
    always_comb begin
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_rsp_take = 1'b0;
        req_ready  = '0;
        rsp_valid  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant == IDW'(i)) begin
                w_sel_a = req_a[i*WIDTH +: WIDTH];
                w_sel_b = req_b[i*WIDTH +: WIDTH];
            end
            // rst gating keeps req_ready low while reset is held even though
            // the state register already sits in IDLE.
            req_ready[i] = (r_state == S_IDLE) && !rst && w_found && (w_grant == IDW'(i));
            rsp_valid[i] = (r_state == S_RESP) && (r_grant_id == IDW'(i));
            if ((r_grant_id == IDW'(i)) && rsp_ready[i]) begin
                w_rsp_take = 1'b1;
            end
        end
    end

    assign w_rr_next = (r_grant_id == IDW'(N_REQ - 1)) ? '0 : r_grant_id + IDW'(1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_RESP;
            S_RESP:  if (w_rsp_take) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_rsp_data <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_found) begin
                r_op_a     <= w_sel_a;
                r_op_b     <= w_sel_b;
                r_grant_id <= w_grant;
            end
            // add_c is only meaningful while the registered operands drive the adder.
            if (r_state == S_EXEC) begin
                r_rsp_data <= add_c;
            end
            if ((r_state == S_RESP) && w_rsp_take) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    assign add_a    = r_op_a;
    assign add_b    = r_op_b;
    assign rsp_data = r_rsp_data;
    assign busy     = (r_state != S_IDLE);
    assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_adder_share_arbiter                                       |
// | Description : Self-checking bench for adder_share_arbiter. Models the      |
// |               shared adder, runs a table of single operations, then        |
// |               fairness, backpressure, reset and late-request sequences.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_adder_share_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 16;
    localparam int IDW   = 2;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]       rsp_data;
    logic [WIDTH-1:0]       add_a;
    logic [WIDTH-1:0]       add_b;
    logic [WIDTH-1:0]       add_c;
    logic                   busy;
    logic [IDW-1:0]         grant_id;

    adder_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .add_a(add_a), .add_b(add_b), .add_c(add_c),
        .busy(busy), .grant_id(grant_id)
    );

    // Shared adder model: carry-out discarded.
    assign add_c = add_a + add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] d;
    } exp_t;

    vec_t tbl[7];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [15:0] a, input logic [15:0] b);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
    endtask

    task automatic push_exp(input int id, input logic [15:0] d);
        exp_t e;
        e.id = id;
        e.d  = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Scoreboard: every completed response handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst && ((rsp_valid & rsp_ready) != '0)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", {28'd0, rsp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_rsp_id", {28'd0, rsp_valid}, {28'd0, oh(e.id)});
                chk("sb_rsp_data", {16'd0, rsp_data}, {16'd0, e.d});
            end
        end
    end

    // Single operation, requester alone: grant, EXEC, RESP, back to IDLE.
    task automatic run_single(input vec_t v);
        set_op(v.id, v.a, v.b);
        req_valid = oh(v.id);
        #1;
        chk("single_grant", {28'd0, req_ready}, {28'd0, oh(v.id)});
        push_exp(v.id, v.exp);
        step();
        req_valid = '0;
        chk("single_exec_busy", {31'd0, busy}, 32'd1);
        chk("single_exec_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("single_add_a", {16'd0, add_a}, {16'd0, v.a});
        chk("single_add_b", {16'd0, add_b}, {16'd0, v.b});
        step();
        chk("single_rsp_valid", {28'd0, rsp_valid}, {28'd0, oh(v.id)});
        chk("single_rsp_data", {16'd0, rsp_data}, {16'd0, v.exp});
        step();
        chk("single_rsp_pulse", {28'd0, rsp_valid}, 32'd0);
        chk("single_idle_busy", {31'd0, busy}, 32'd0);
    endtask

    logic [15:0] fa[4];
    logic [15:0] fb[4];
    logic [15:0] e2, e3;
    int          wait_n;

    initial begin
        tbl[0] = '{0, 16'h1234, 16'h0101, 16'h1335};
        tbl[1] = '{1, 16'hFFFF, 16'h0001, 16'h0000};
        tbl[2] = '{2, 16'h8000, 16'h8000, 16'h0000};
        tbl[3] = '{3, 16'h00FF, 16'hFF01, 16'h0000};
        tbl[4] = '{1, 16'h7FFF, 16'h0001, 16'h8000};
        tbl[5] = '{2, 16'hABCD, 16'h1111, 16'hBCDE};
        tbl[6] = '{3, 16'h0000, 16'h0000, 16'h0000};

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;
        #12;
        chk("reset_req_ready", {28'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_grant_id", {30'd0, grant_id}, 32'd0);
        chk("reset_add_a", {16'd0, add_a}, 32'd0);
        chk("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
        step();
        rst       = 1'b0;
        rsp_ready = '1;

        // Table of isolated operations, including wrap-around sums.
        for (int n = 0; n < 7; n++) begin
            run_single(tbl[n]);
        end

        // Fairness: all requesters valid, expect 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            fa[i] = 16'h1000 * 16'(i + 1) + 16'(i);
            fb[i] = 16'hF0F0 + 16'(i * 3);
            set_op(i, fa[i], fb[i]);
        end
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("fair_grant", {28'd0, req_ready}, {28'd0, oh(k % 4)});
            push_exp(k % 4, fa[k % 4] + fb[k % 4]);
            step();
            if (k == 4) req_valid = '0;
            chk("fair_grant_id", {30'd0, grant_id}, k % 4);
            step();
            step();
        end

        // Backpressure on requester 2, then requester 3 is next.
        do_reset();
        rsp_ready = 4'b1011;
        set_op(2, 16'h4321, 16'h1111);
        set_op(3, 16'h0F00, 16'h00F0);
        e2 = 16'h5432;
        e3 = 16'h0FF0;
        req_valid = 4'b1100;
        #1;
        chk("bp_grant2", {28'd0, req_ready}, 32'h4);
        push_exp(2, e2);
        step();
        req_valid = 4'b1000;
        step();
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", {28'd0, rsp_valid}, 32'h4);
            chk("bp_rsp_data", {16'd0, rsp_data}, {16'd0, e2});
            chk("bp_req_ready", {28'd0, req_ready}, 32'd0);
            chk("bp_busy", {31'd0, busy}, 32'd1);
            step();
        end
        rsp_ready = '1;
        step();
        chk("bp_next_grant3", {28'd0, req_ready}, 32'h8);
        push_exp(3, e3);
        step();
        req_valid = '0;
        step();
        step();

        // Reset during EXEC: operation discarded, outputs back to reset values.
        do_reset();
        set_op(2, 16'h2222, 16'h3333);
        req_valid = 4'b0100;
        step();
        chk("rst_exec_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
        chk("rst_add_a", {16'd0, add_a}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_no_rsp", {28'd0, rsp_valid}, 32'd0);
        set_op(1, 16'h0102, 16'h0304);
        req_valid = 4'b0010;
        #1;
        chk("rst_after_grant1", {28'd0, req_ready}, 32'h2);
        push_exp(1, 16'h0406);
        step();
        req_valid = '0;
        step();
        chk("rst_after_rsp", {28'd0, rsp_valid}, 32'h2);
        step();

        // Late request: requester 1 rises during requester 0's RESP.
        do_reset();
        set_op(0, 16'h0010, 16'h0020);
        req_valid = 4'b0001;
        #1;
        chk("late_grant0", {28'd0, req_ready}, 32'h1);
        push_exp(0, 16'h0030);
        step();
        req_valid = '0;
        step();
        set_op(1, 16'hFFF0, 16'h0020);
        req_valid = 4'b0010;
        #1;
        chk("late_held_off", {28'd0, req_ready}, 32'd0);
        chk("late_resp0", {28'd0, rsp_valid}, 32'h1);
        step();
        chk("late_grant1", {28'd0, req_ready}, 32'h2);
        push_exp(1, 16'h0010);
        step();
        req_valid = '0;
        step();
        step();

        // Drain: every expected response must have appeared.
        wait_n = 0;
        while (sb.size() != 0 && wait_n < 20) begin
            step();
            wait_n++;
        end
        chk("sb_drain", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
